// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if
//   Groups the execute-side request/response handshakes and the word-wide
//   port-B memory bus used by lsu_mem_port.
//
//   Request  : req_valid, req_ready, req_we, req_size, req_unsigned,
//              req_addr, req_wdata
//   Response : rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   Memory   : B_EnWR, B_ABus, B_DBusW (to memory), B_DBusR (from memory)
//
//   slave  : the load/store unit view (accepts requests, drives the memory bus)
//   master : the execute stage plus memory view (issues requests, serves bus)
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        B_EnWR;
    logic [31:0] B_ABus;
    logic [31:0] B_DBusW;
    logic [31:0] B_DBusR;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, B_DBusR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output B_EnWR, B_ABus, B_DBusW
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, B_DBusR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  B_EnWR, B_ABus, B_DBusW
    );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Load/store initiator for port B of the byte-addressed data memory.
//   Accepts byte/half/word loads and stores, sign- or zero-extends loads and
//   performs sub-word stores as read-modify-write because the memory only
//   writes whole 4-byte words. One response is returned per request.
//
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - lsu_mem_port_if.slave: request/response handshakes and the
//              EnWR/ABus/DBusW/DBusR memory bus
//
//   Parameter:
//     MEM_BYTES - memory size in bytes; every access touches 4 bytes, so the
//                 highest legal address is MEM_BYTES-4.
//
//   Optional feature macro: LSU_ALIGN_CHECK_EN
//     defined   - misaligned half (addr[0]) and word (addr[1:0]) requests are
//                 rejected with rsp_err and never reach the bus.
//     undefined - any in-bounds byte address is accepted.
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_port_if.slave bus
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              accept;
    logic              size_bad;
    logic              out_of_bounds;
    logic              misaligned;
    logic              req_err;

    // request latched at accept
    logic              we_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic [DATA_W-1:0] addr_p0;
    logic              err_p0;
    // word to drive in WRITE and formatted load result for RESP
    logic [DATA_W-1:0] wword_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Extend the addressed low byte/half of a read word to a full result.
    function automatic logic [DATA_W-1:0] load_fmt(
        input logic [1:0]        size,
        input logic              uns,
        input logic [DATA_W-1:0] word
    );
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] ext;
        b = word[7:0];
        h = word[15:0];
        case (size)
            2'b00: begin
                ext = b;
                load_fmt = uns ? {24'h0, word[7:0]} : ext;
            end
            2'b01: begin
                ext = h;
                load_fmt = uns ? {16'h0, word[15:0]} : ext;
            end
            default: load_fmt = word;
        endcase
    endfunction

    // Insert the store byte/half into the word read back from memory.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [1:0]        size,
        input logic [DATA_W-1:0] rd,
        input logic [DATA_W-1:0] wd
    );
        if (size == 2'b00) store_merge = {rd[31:8], wd[7:0]};
        else               store_merge = {rd[31:16], wd[15:0]};
    endfunction

    assign size_bad      = (bus.req_size == 2'b11);
    // 33-bit compare so an address near 2^32 cannot wrap into range.
    assign out_of_bounds = ({1'b0, bus.req_addr} > 33'(MEM_BYTES - 4));

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = size_bad || out_of_bounds || misaligned;
    assign accept  = (state_q == IDLE) && bus.req_valid;

    // ---- control: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                   state_d = RESP;
                    else if (!bus.req_we || bus.req_size != 2'b10) state_d = READ;
                    else                                           state_d = WRITE;
                end
            end
            READ:    state_d = we_p0 ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- data: request capture (p0) and memory-stage results (p1) ----
    // No reset here: every output that exposes these registers is gated by
    // the reset state, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.req_we;
            size_p0  <= bus.req_size;
            uns_p0   <= bus.req_unsigned;
            addr_p0  <= bus.req_addr;
            err_p0   <= req_err;
            wword_p1 <= bus.req_wdata;
            rdata_p1 <= '0;
        end else if (state_q == READ) begin
            if (we_p0) wword_p1 <= store_merge(size_p0, bus.B_DBusR, wword_p1);
            else       rdata_p1 <= load_fmt(size_p0, uns_p0, bus.B_DBusR);
        end
    end

    // ---- outputs: decodes of registered state only ----
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = (state_q == RESP) ? rdata_p1 : '0;
    assign bus.rsp_err   = (state_q == RESP) && err_p0;
    assign bus.B_EnWR    = (state_q == WRITE);
    assign bus.B_ABus    = ((state_q == READ) || (state_q == WRITE)) ? addr_p0 : '0;
    assign bus.B_DBusW   = (state_q == WRITE) ? wword_p1 : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    lsu_mem_port_if bus ();

    lsu_mem_port #(.MEM_BYTES(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed 4 KiB memory model, little-endian word access.
    logic [7:0] mem [0:4095];

    always_comb begin
        bus.B_DBusR = 32'h0;
        if (bus.B_ABus <= 32'd4092)
            bus.B_DBusR = {mem[bus.B_ABus[11:0] + 12'd3], mem[bus.B_ABus[11:0] + 12'd2],
                           mem[bus.B_ABus[11:0] + 12'd1], mem[bus.B_ABus[11:0]]};
    end

    always @(posedge clk) begin
        if (bus.B_EnWR && bus.B_ABus <= 32'd4092) begin
            mem[bus.B_ABus[11:0]]         <= bus.B_DBusW[7:0];
            mem[bus.B_ABus[11:0] + 12'd1] <= bus.B_DBusW[15:8];
            mem[bus.B_ABus[11:0] + 12'd2] <= bus.B_DBusW[23:16];
            mem[bus.B_ABus[11:0] + 12'd3] <= bus.B_DBusW[31:24];
        end
    end

    int          lat, pulses, rdy_busy;
    logic [31:0] rdata, dbusw, abus;
    logic        err;

    // Issue one request with rsp_ready high and observe it to completion.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b1;
        @(posedge clk);
        #1;
        // scramble fields: the block must use what it latched
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'h0000_0FF0;
        bus.req_wdata    = 32'h0BAD_0BAD;
        bus.req_size     = 2'b10;
        bus.req_unsigned = ~uns;
        lat = 0; pulses = 0; rdy_busy = 0;
        rdata = 32'hxxxx_xxxx; err = 1'bx; dbusw = 32'h0; abus = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (bus.req_ready) rdy_busy++;
            if (bus.B_EnWR) begin
                pulses++;
                dbusw = bus.B_DBusW;
                abus  = bus.B_ABus;
            end
            if (bus.rsp_valid) begin
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        tests++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got %h/%b want 0/0", bus.rsp_rdata, bus.rsp_err); end
        tests++; if (bus.B_EnWR !== 1'b0 || bus.B_ABus !== 32'h0 || bus.B_DBusW !== 32'h0) begin
            fails++; $display("FAIL reset_bus got %b/%h/%h want 0/0/0", bus.B_EnWR, bus.B_ABus, bus.B_DBusW); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL sw_pulses got %0d want 1", pulses); end
        tests++; if (dbusw !== 32'hDEADBEEF || abus !== 32'h100) begin fails++; $display("FAIL sw_bus got %h@%h want deadbeef@00000100", dbusw, abus); end
        tests++; if (lat !== 2 || err !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL sw_rsp got lat %0d err %b rdata %h want 2 0 0", lat, err, rdata); end
        tests++; if (rdy_busy !== 0) begin fails++; $display("FAIL sw_ready_busy got %0d want 0", rdy_busy); end
        issue(1'b0, 2'b10, 1'b1, 32'h100, 32'h0);
        tests++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin fails++; $display("FAIL lw_data got %h/%b want deadbeef/0", rdata, err); end
        tests++; if (lat !== 2 || pulses !== 0) begin fails++; $display("FAIL lw_timing got lat %0d pulses %0d want 2 0", lat, pulses); end
    endtask

    task automatic test_byte();
        issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h555555AA);
        tests++; if (dbusw !== 32'h112233AA || pulses !== 1) begin fails++; $display("FAIL sb_merge got %h pulses %0d want 112233aa 1", dbusw, pulses); end
        tests++; if (lat !== 3 || err !== 1'b0) begin fails++; $display("FAIL sb_lat got %0d err %b want 3 0", lat, err); end
        issue(1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
        tests++; if (rdata !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb got %h want ffffffaa", rdata); end
        issue(1'b0, 2'b00, 1'b1, 32'h200, 32'h0);
        tests++; if (rdata !== 32'h000000AA) begin fails++; $display("FAIL lbu got %h want 000000aa", rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        tests++; if (rdata !== 32'h112233AA) begin fails++; $display("FAIL lw_after_sb got %h want 112233aa", rdata); end
    endtask

    task automatic test_half();
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hFFFFFFFF);
        issue(1'b1, 2'b01, 1'b0, 32'h300, 32'h12348001);
        tests++; if (dbusw !== 32'hFFFF8001 || lat !== 3) begin fails++; $display("FAIL sh_merge got %h lat %0d want ffff8001 3", dbusw, lat); end
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        tests++; if (rdata !== 32'hFFFF8001) begin fails++; $display("FAIL lw_after_sh got %h want ffff8001", rdata); end
        issue(1'b0, 2'b01, 1'b0, 32'h300, 32'h0);
        tests++; if (rdata !== 32'hFFFF8001) begin fails++; $display("FAIL lh got %h want ffff8001", rdata); end
        issue(1'b0, 2'b01, 1'b1, 32'h300, 32'h0);
        tests++; if (rdata !== 32'h00008001) begin fails++; $display("FAIL lhu got %h want 00008001", rdata); end
    endtask

    task automatic test_bounds();
        issue(1'b1, 2'b10, 1'b0, 32'd4092, 32'hA5A55A5A);
        tests++; if (err !== 1'b0 || pulses !== 1) begin fails++; $display("FAIL sw_4092 got err %b pulses %0d want 0 1", err, pulses); end
        issue(1'b0, 2'b10, 1'b0, 32'd4092, 32'h0);
        tests++; if (rdata !== 32'hA5A55A5A || err !== 1'b0) begin fails++; $display("FAIL lw_4092 got %h/%b want a5a55a5a/0", rdata, err); end
        issue(1'b0, 2'b10, 1'b0, 32'd4093, 32'h0);
        tests++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 1) begin fails++; $display("FAIL lw_4093 got err %b rdata %h lat %0d want 1 0 1", err, rdata, lat); end
        issue(1'b1, 2'b10, 1'b0, 32'd4093, 32'h12345678);
        tests++; if (err !== 1'b1 || pulses !== 0) begin fails++; $display("FAIL sw_4093 got err %b pulses %0d want 1 0", err, pulses); end
        issue(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0);
        tests++; if (err !== 1'b1 || lat !== 1) begin fails++; $display("FAIL lb_wrap got err %b lat %0d want 1 1", err, lat); end
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        tests++; if (err !== 1'b1 || rdata !== 32'h0) begin fails++; $display("FAIL size11_load got err %b rdata %h want 1 0", err, rdata); end
        issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h0);
        tests++; if (err !== 1'b1 || pulses !== 0) begin fails++; $display("FAIL size11_store got err %b pulses %0d want 1 0", err, pulses); end
    endtask

    task automatic test_align();
        // bytes 0x101..0x102 hold BE, AD from the earlier sw of DEADBEEF
        issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        tests++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 1) begin fails++; $display("FAIL lh_unaligned got err %b rdata %h lat %0d want 1 0 1", err, rdata, lat); end
`else
        tests++; if (err !== 1'b0 || rdata !== 32'hFFFFADBE) begin fails++; $display("FAIL lh_unaligned got err %b rdata %h want 0 ffffadbe", err, rdata); end
`endif
        issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL lhu_unaligned got err %b want 1", err); end
`else
        tests++; if (rdata !== 32'h0000ADBE) begin fails++; $display("FAIL lhu_unaligned got %h want 0000adbe", rdata); end
`endif
    endtask

    task automatic test_backpressure();
        int waited;
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h200; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        // a different request left on the bus must be ignored while busy
        bus.req_addr = 32'h100;
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        tests++; if (waited !== 2) begin fails++; $display("FAIL bp_latency got %0d want 2", waited); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h112233AA || bus.req_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold cycle %0d got v%b %h r%b want v1 112233aa r0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready); end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v%b r%b want v0 r1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_reset_write();
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h400;
        bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.B_EnWR !== 1'b1) begin fails++; $display("FAIL rstw_in_write got EnWR %b want 1", bus.B_EnWR); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.B_EnWR !== 1'b0 || bus.B_ABus !== 32'h0 || bus.B_DBusW !== 32'h0) begin
            fails++; $display("FAIL rstw_async_bus got %b/%h/%h want 0/0/0", bus.B_EnWR, bus.B_ABus, bus.B_DBusW); end
        tests++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rstw_async_ctl got r%b v%b want r1 v0", bus.req_ready, bus.rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rstw_no_rsp got %b want 0", bus.rsp_valid); end
        end
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        tests++; if (rdata !== 32'h12345678) begin fails++; $display("FAIL rstw_mem_unchanged got %h want 12345678", rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_bounds();
        test_align();
        test_backpressure();
        test_reset_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
